// File: rtl/btn_event_gen.sv
// btn_event_gen: turns raw, bouncy, asynchronous push-button pins into clean
// clk-synchronous level and single-cycle event pulses. Each button is an
// independent channel: 2-FF synchroniser with polarity fix, debounce FSM,
// and press / release / long-press / auto-repeat pulse generation.
module btn_event_gen #(
  parameter int unsigned     NBTN         = 7,
  parameter logic [NBTN-1:0] ACTIVE_LOW   = NBTN'(7'b0000001),
  parameter int unsigned     DEBOUNCE_CYC = 250000,
  parameter int unsigned     LONG_CYC     = 12500000,
  parameter int unsigned     REPEAT_CYC   = 2500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_in,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] press_pulse,
  output logic [NBTN-1:0] release_pulse,
  output logic [NBTN-1:0] long_pulse,
  output logic [NBTN-1:0] repeat_pulse
);

  // One counter width serves every timing phase; it only ever reaches
  // (terminal - 1) before being cleared, so clog2 of the largest period fits.
  localparam int unsigned MAX_DL  = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
  localparam int unsigned MAX_CYC = (MAX_DL > REPEAT_CYC) ? MAX_DL : REPEAT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESS_W = 3'd1,
    HELD    = 3'd2,
    RPT     = 3'd3,
    REL_W   = 3'd4
  } state_e;

  // Synchroniser stages hold the polarity-corrected "pressed" level, so
  // their reset value 0 means "not pressed" for every button.
  logic [NBTN-1:0]  sync1_d, sync1_q;
  logic [NBTN-1:0]  sync2_q;

  state_e           state_d [NBTN];
  state_e           state_q [NBTN];
  logic [CNT_W-1:0] cnt_d   [NBTN];
  logic [CNT_W-1:0] cnt_q   [NBTN];

  logic [NBTN-1:0]  level_d,  level_q;
  logic [NBTN-1:0]  press_d,  press_q;
  logic [NBTN-1:0]  rel_d,    rel_q;
  logic [NBTN-1:0]  long_d,   long_q;
  logic [NBTN-1:0]  rpt_d,    rpt_q;

  // Polarity fix ahead of the first flop so the FSM only sees 1 = pressed.
  always_comb begin
    sync1_d = btn_in ^ ACTIVE_LOW;
  end

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce / hold FSM: next state, counter and pulse decode.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
    rpt_d   = '0;
    for (int i = 0; i < NBTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i] + CNT_ONE;
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i]) state_d[i] = PRESS_W;
        end
        PRESS_W: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            state_d[i] = REL_W;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == LONG_LAST) begin
            state_d[i] = RPT;
            cnt_d[i]   = '0;
            long_d[i]  = 1'b1;
          end
        end
        RPT: begin
          if (!sync2_q[i]) begin
            state_d[i] = REL_W;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == RPT_LAST) begin
            cnt_d[i]   = '0;
            rpt_d[i]   = 1'b1;
          end
        end
        REL_W: begin
          // A bounce back to pressed restarts long-press timing silently.
          if (sync2_q[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
            rel_d[i]   = 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      rpt_q   <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = rpt_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with short timing parameters.
// Every cycle of each scenario compares all five output vectors against
// hand-computed event times.
module tb_btn_event_gen;

  localparam int unsigned NBTN = 7;
  localparam logic [6:0]  AL   = 7'b0000001;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NBTN-1:0] pressed = '0;
  logic [NBTN-1:0] btn_in;
  logic [NBTN-1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

  int n_chk  = 0;
  int n_pass = 0;

  // Pins carry the electrical level: active-low buttons read 0 when pressed.
  assign btn_in = pressed ^ AL;

  always #5 clk = ~clk;

  btn_event_gen #(
    .NBTN(NBTN),
    .ACTIVE_LOW(AL),
    .DEBOUNCE_CYC(4),
    .LONG_CYC(20),
    .REPEAT_CYC(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (lvl|prs|rel|lng|rpt)", tag, got, exp);
  endtask

  function automatic logic [63:0] outs();
    return {29'd0, btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse};
  endfunction

  // Advance one clock and compare outputs just after the edge.
  task automatic cyc(input string tag, input logic [6:0] l, input logic [6:0] p,
                     input logic [6:0] r, input logic [6:0] g, input logic [6:0] t);
    @(posedge clk);
    #1;
    chk(tag, outs(), {29'd0, l, p, r, g, t});
  endtask

  // Press mask m, hold 10 cycles, release; expect press at +7, release at +7.
  task automatic press_hold_release(input string tag, input logic [6:0] m);
    pressed = pressed | m;
    for (int c = 1; c <= 10; c++)
      cyc(tag, (c >= 7) ? m : 7'd0, (c == 7) ? m : 7'd0, 7'd0, 7'd0, 7'd0);
    pressed = pressed & ~m;
    for (int c = 1; c <= 9; c++)
      cyc(tag, (c < 7) ? m : 7'd0, 7'd0, (c == 7) ? m : 7'd0, 7'd0, 7'd0);
  endtask

  initial begin
    // Reset state, btn[0] idle high (not pressed).
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outs(), 64'd0);
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) cyc("idle", 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);

    // Clean press of button 2.
    press_hold_release("clean2", 7'b0000100);

    // Glitches: 3 high, 3 low, five times -> nothing.
    for (int k = 0; k < 5; k++) begin
      pressed[2] = 1'b1;
      for (int c = 0; c < 3; c++) cyc("glitch", 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
      pressed[2] = 1'b0;
      for (int c = 0; c < 3; c++) cyc("glitch", 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    end
    for (int c = 0; c < 6; c++) cyc("glitch_tail", 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);

    // Long press of button 1: long at +27, repeats at +32,+37,...
    pressed[1] = 1'b1;
    for (int c = 1; c <= 60; c++)
      cyc("long1", (c >= 7) ? 7'b0000010 : 7'd0, (c == 7) ? 7'b0000010 : 7'd0, 7'd0,
          (c == 27) ? 7'b0000010 : 7'd0,
          (c >= 32 && ((c - 32) % 5) == 0) ? 7'b0000010 : 7'd0);
    // Last repeat (edge 62) lands before the FSM sees the release.
    pressed[1] = 1'b0;
    for (int c = 1; c <= 9; c++)
      cyc("long1_rel", (c < 7) ? 7'b0000010 : 7'd0, 7'd0, (c == 7) ? 7'b0000010 : 7'd0,
          7'd0, (c == 2) ? 7'b0000010 : 7'd0);
    for (int c = 0; c < 8; c++) cyc("long1_quiet", 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);

    // Active-low button 0.
    press_hold_release("pwr0", 7'b0000001);

    // Simultaneous press of buttons 1,2,3.
    press_hold_release("multi", 7'b0001110);

    // Button 4 into repeat, then async reset with button still held.
    pressed[4] = 1'b1;
    for (int c = 1; c <= 30; c++)
      cyc("rpt4", (c >= 7) ? 7'b0010000 : 7'd0, (c == 7) ? 7'b0010000 : 7'd0, 7'd0,
          (c == 27) ? 7'b0010000 : 7'd0, 7'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", outs(), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold", outs(), 64'd0);
    rst = 1'b0;
    for (int c = 1; c <= 9; c++)
      cyc("repress4", (c >= 7) ? 7'b0010000 : 7'd0, (c == 7) ? 7'b0010000 : 7'd0,
          7'd0, 7'd0, 7'd0);
    pressed[4] = 1'b0;
    for (int c = 1; c <= 9; c++)
      cyc("rel4", (c < 7) ? 7'b0010000 : 7'd0, 7'd0, (c == 7) ? 7'b0010000 : 7'd0,
          7'd0, 7'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
